// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: debounced keys drive a clock-enable FSM (step, free-run, N-cycle burst, halt).
// Define CPU_RUN_BREAKPOINT_EN to compile in the PC breakpoint compare and halt cause 01.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 16
) (
    input  logic             clock_50,
    input  logic             n_reset,
    input  logic             key_step,
    input  logic             key_run,
    input  logic             mode,
    input  logic [CNT_W-1:0] run_count,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    input  logic             led_write,
    output logic             cpu_ce,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [31:0]      retired
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_ZERO   = DB_W'(0);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] BURST_ZERO = CNT_W'(0);

    localparam logic [1:0] CAUSE_USER  = 2'b00;
    localparam logic [1:0] CAUSE_BP    = 2'b01;
    localparam logic [1:0] CAUSE_LED   = 2'b10;
    localparam logic [1:0] CAUSE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    // Key index 0 is step, index 1 is run; all keys are active-low.
    logic [1:0]      w_keys;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_level;
    logic [1:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [2];
    logic            w_step_p;
    logic            w_run_p;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_nx;
    logic [1:0]       r_halt_cause;
    logic [1:0]       w_cause_nx;
    logic             r_cpu_ce;
    logic             r_halted;
    logic [31:0]      r_retired;
    logic             w_bp_hit;

    assign w_keys   = {key_run, key_step};
    assign w_step_p = r_press[0];
    assign w_run_p  = r_press[1];

    // Synchronise both keys, then accept a new level only after it holds for DEBOUNCE_CYCLES.
    always_ff @(posedge clock_50 or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_level <= 2'b11;
            r_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= DB_ZERO;
            end
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_level[i]  <= r_sync2[i];
                        r_db_cnt[i] <= DB_ZERO;
                        r_press[i]  <= ~r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
                        r_press[i]  <= 1'b0;
                    end
                end else begin
                    r_db_cnt[i] <= DB_ZERO;
                    r_press[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef CPU_RUN_BREAKPOINT_EN
    logic r_skip;

    // The first cycle after leaving HALT ignores the compare so a resume can move off the breakpoint.
    assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_skip;

    // Flags the first RUN/BURST cycle following a HALT exit.
    always_ff @(posedge clock_50 or negedge n_reset) begin
        if (!n_reset) begin
            r_skip <= 1'b0;
        end else begin
            r_skip <= (r_state == ST_HALT) &&
                      ((w_state_nx == ST_RUN) || (w_state_nx == ST_BURST));
        end
    end
`else
    logic w_unused_bp;

    assign w_bp_hit    = 1'b0;
    assign w_unused_bp = &{1'b0, pc, bp_addr, bp_valid};
`endif

    // Next-state and halt-cause selection; breakpoint beats abort beats LED beats burst-done.
    always_comb begin
        w_state_nx = r_state;
        w_burst_nx = r_burst_cnt;
        w_cause_nx = r_halt_cause;
        case (r_state)
            ST_HALT: begin
                if (w_run_p) begin
                    if (!mode) begin
                        w_state_nx = ST_RUN;
                    end else if (run_count != BURST_ZERO) begin
                        w_state_nx = ST_BURST;
                        w_burst_nx = run_count;
                    end else begin
                        w_state_nx = ST_HALT;
                        w_cause_nx = CAUSE_BURST;
                    end
                end else if (w_step_p) begin
                    w_state_nx = ST_STEP;
                end else begin
                    w_state_nx = ST_HALT;
                end
            end
            ST_STEP: begin
                w_state_nx = ST_HALT;
                if (led_write) begin
                    w_cause_nx = CAUSE_LED;
                end else begin
                    w_cause_nx = CAUSE_USER;
                end
            end
            ST_RUN: begin
                if (w_bp_hit) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_BP;
                end else if (w_run_p) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_USER;
                end else if (r_cpu_ce && led_write) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_LED;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_BURST: begin
                w_burst_nx = r_burst_cnt - BURST_ONE;
                if (w_bp_hit) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_BP;
                    w_burst_nx = BURST_ZERO;
                end else if (w_run_p) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_USER;
                    w_burst_nx = BURST_ZERO;
                end else if (r_cpu_ce && led_write) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_LED;
                    w_burst_nx = BURST_ZERO;
                end else if (r_burst_cnt == BURST_ONE) begin
                    w_state_nx = ST_HALT;
                    w_cause_nx = CAUSE_BURST;
                    w_burst_nx = BURST_ZERO;
                end else begin
                    w_state_nx = ST_BURST;
                end
            end
            default: begin
                w_state_nx = ST_HALT;
                w_burst_nx = BURST_ZERO;
                w_cause_nx = CAUSE_USER;
            end
        endcase
    end

    // State register with registered decode of the enable, halt flag and retire counter.
    always_ff @(posedge clock_50 or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= ST_HALT;
            r_burst_cnt  <= BURST_ZERO;
            r_halt_cause <= CAUSE_USER;
            r_cpu_ce     <= 1'b0;
            r_halted     <= 1'b1;
            r_retired    <= 32'd0;
        end else begin
            r_state      <= w_state_nx;
            r_burst_cnt  <= w_burst_nx;
            r_halt_cause <= w_cause_nx;
            r_cpu_ce     <= (w_state_nx != ST_HALT);
            r_halted     <= (w_state_nx == ST_HALT);
            if (r_cpu_ce) begin
                r_retired <= r_retired + 32'd1;
            end else begin
                r_retired <= r_retired;
            end
        end
    end

    assign cpu_ce     = r_cpu_ce;
    assign halted     = r_halted;
    assign halt_cause = r_halt_cause;
    assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed scoreboard bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4; the bench also models the core's PC.
module tb_cpu_run_ctrl;

    localparam int CNT_W = 16;

    logic             clock_50;
    logic             n_reset;
    logic             key_step;
    logic             key_run;
    logic             mode;
    logic [CNT_W-1:0] run_count;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             led_write;
    logic             cpu_ce;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [31:0]      retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Core model: one instruction per cpu_ce cycle, counted mid-cycle; pc shows the next fetch address.
    logic [31:0] total_pulses = 32'd0;
    logic [31:0] pc_base      = 32'd0;
    logic [31:0] led_base     = 32'd0;
    logic [31:0] led_at       = 32'hFFFF_FFFF;
    logic [31:0] reset_base   = 32'd0;

    string       q_tag   [$];
    logic [1:0]  q_cause [$];
    int          q_pulses[$];
    logic [31:0] q_base  [$];

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (CNT_W)
    ) dut (
        .clock_50  (clock_50),
        .n_reset   (n_reset),
        .key_step  (key_step),
        .key_run   (key_run),
        .mode      (mode),
        .run_count (run_count),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .led_write (led_write),
        .cpu_ce    (cpu_ce),
        .halted    (halted),
        .halt_cause(halt_cause),
        .retired   (retired)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    always @(negedge clock_50) begin
        if (cpu_ce === 1'b1) begin
            total_pulses <= total_pulses + 32'd1;
        end
    end

    assign pc        = (total_pulses - pc_base) << 2;
    assign led_write = (cpu_ce === 1'b1) && ((total_pulses - led_base) == led_at);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] cause, input int pulses);
        q_tag.push_back(tag);
        q_cause.push_back(cause);
        q_pulses.push_back(pulses);
        q_base.push_back(total_pulses);
    endtask

    // Hold the selected keys low long enough to debounce, then release and let the release settle.
    task automatic press(input logic do_step, input logic do_run);
        if (do_step) key_step = 1'b0;
        if (do_run)  key_run  = 1'b0;
        tick(10);
        key_step = 1'b1;
        key_run  = 1'b1;
        tick(10);
    endtask

    // Wait (bounded) for the sequencer to halt, then pop the oldest expectation and compare.
    task automatic complete();
        string       tag;
        logic [1:0]  ec;
        int          ep;
        logic [31:0] b;
        logic [31:0] got;
        for (int i = 0; i < 80 && halted !== 1'b1; i++) tick();
        tag = q_tag.pop_front();
        ec  = q_cause.pop_front();
        ep  = q_pulses.pop_front();
        b   = q_base.pop_front();
        got = total_pulses - b;
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check({tag, "_ce_low"}, {31'd0, cpu_ce}, 32'd0);
        check({tag, "_cause"}, {30'd0, halt_cause}, {30'd0, ec});
        if (ep >= 0) check({tag, "_pulses"}, got, ep);
        else         check({tag, "_pulses_nonzero"}, {31'd0, got != 32'd0}, 32'd1);
        check({tag, "_retired"}, retired, total_pulses - reset_base);
    endtask

    initial begin
        n_reset   = 1'b0;
        key_step  = 1'b1;
        key_run   = 1'b1;
        mode      = 1'b0;
        run_count = 16'd0;
        bp_addr   = 32'd0;
        bp_valid  = 1'b0;
        tick(3);
        check("rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd1);
        check("rst_cause", {30'd0, halt_cause}, 32'd0);
        check("rst_retired", retired, 32'd0);
        n_reset    = 1'b1;
        reset_base = total_pulses;
        tick(2);

        push("step", 2'b00, 1);
        press(1'b1, 1'b0);
        complete();

        push("bounce", 2'b00, 0);
        key_step = 1'b0; tick(2);
        key_step = 1'b1; tick(1);
        key_step = 1'b0; tick(2);
        key_step = 1'b1; tick(15);
        complete();

        mode = 1'b1; run_count = 16'd5;
        push("burst5", 2'b11, 5);
        press(1'b0, 1'b1);
        complete();

        led_base = total_pulses; led_at = 32'd1;
        push("step_led", 2'b10, 1);
        press(1'b1, 1'b0);
        complete();
        led_at = 32'hFFFF_FFFF;

        run_count = 16'd0;
        push("burst0", 2'b11, 0);
        press(1'b0, 1'b1);
        complete();

        mode = 1'b0; pc_base = total_pulses; bp_addr = 32'h10; bp_valid = 1'b1;
`ifdef CPU_RUN_BREAKPOINT_EN
        push("bp_hit", 2'b01, 4);
        press(1'b0, 1'b1);
        complete();
        check("bp_pc", pc, 32'h10);
`endif
        push("bp_pass", 2'b00, -1);
        press(1'b0, 1'b1);
        check("bp_pass_running", {31'd0, halted}, 32'd0);
        check("bp_pass_pc", {31'd0, pc > 32'h10}, 32'd1);
        press(1'b0, 1'b1);
        complete();
        bp_valid = 1'b0;

        led_base = total_pulses; led_at = 32'd3;
        push("led_run", 2'b10, 3);
        press(1'b0, 1'b1);
        complete();
        led_at = 32'hFFFF_FFFF;

        push("prio_stop", 2'b00, -1);
        press(1'b1, 1'b1);
        check("prio_running", {31'd0, halted}, 32'd0);
        check("prio_ce", {31'd0, cpu_ce}, 32'd1);
        press(1'b0, 1'b1);
        complete();

        mode = 1'b1; run_count = 16'd4;
        led_base = total_pulses; led_at = 32'd4;
        push("burst_led", 2'b10, 4);
        press(1'b0, 1'b1);
        complete();
        led_at = 32'hFFFF_FFFF;

        run_count = 16'd8;
        begin
            logic [31:0] b;
            b = total_pulses;
            key_run = 1'b0;
            for (int i = 0; i < 40 && (total_pulses - b) < 32'd2; i++) tick();
            check("rst_mid_progress", {31'd0, (total_pulses - b) >= 32'd2}, 32'd1);
            #2 n_reset = 1'b0;
            #1;
            check("rst_mid_ce", {31'd0, cpu_ce}, 32'd0);
            check("rst_mid_retired", retired, 32'd0);
            check("rst_mid_halted", {31'd0, halted}, 32'd1);
            check("rst_mid_cause", {30'd0, halt_cause}, 32'd0);
            key_run = 1'b1;
            tick(3);
            reset_base = total_pulses;
            n_reset = 1'b1;
            tick(20);
            check("post_rst_pulses", total_pulses - reset_base, 32'd0);
            check("post_rst_retired", retired, 32'd0);
            check("post_rst_halted", {31'd0, halted}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
